// File: rtl/ringbuf_mp.sv
// Multi-port ring buffer: up to NW pushes and NR pops per cycle, any DEPTH >= 2.
// Sticky overflow/underflow flags, single-cycle flush, outputs decoded from registered state only.
module ringbuf_mp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NW = 2,
  parameter int NR = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int WNW = $clog2(NW + 1),
  localparam int RNW = $clog2(NR + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic [WNW-1:0]      i_wnum,
  input  logic [NW*WIDTH-1:0] i_data,
  input  logic [RNW-1:0]      i_rnum,
  output logic [NR*WIDTH-1:0] o_data,
  output logic [NR-1:0]       o_valid,
  output logic [CW-1:0]       o_count,
  output logic [CW-1:0]       o_free,
  output logic                o_empty,
  output logic                o_full,
  output logic                o_overflow,
  output logic                o_underflow
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    head;
  logic [IW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  logic             push_ok;
  logic             pop_ok;
  logic [WNW-1:0]   acc_w;
  logic [RNW-1:0]   acc_r;
  logic [IW-1:0]    head_next;
  logic [IW-1:0]    tail_next;
  logic [CW-1:0]    count_next;

  // Compare-and-subtract wrap; repeated so that small DEPTH with wide lanes still lands in range.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int v;
    v = int'(base) + off;
    for (int i = 0; i < 4; i++) begin
      if (v >= DEPTH) v = v - DEPTH;
    end
    return IW'(v);
  endfunction

  // Acceptance looks only at pre-edge occupancy, so same-cycle pops never make room for pushes.
  always_comb begin
    push_ok    = (int'(i_wnum) <= NW) && (int'(i_wnum) <= (DEPTH - int'(count)));
    pop_ok     = (int'(i_rnum) <= NR) && (int'(i_rnum) <= int'(count));
    acc_w      = push_ok ? i_wnum : '0;
    acc_r      = pop_ok ? i_rnum : '0;
    head_next  = wrap_add(head, int'(acc_r));
    tail_next  = wrap_add(tail, int'(acc_w));
    count_next = CW'(int'(count) + int'(acc_w) - int'(acc_r));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Clears come first so a same-edge write to a popped slot wins.
      for (int k = 0; k < NR; k++) begin
        if (pop_ok && (k < int'(i_rnum))) begin
          mem[wrap_add(head, k)] <= '0;
        end
      end
      for (int k = 0; k < NW; k++) begin
        if (push_ok && (k < int'(i_wnum))) begin
          mem[wrap_add(tail, k)] <= i_data[k*WIDTH +: WIDTH];
        end
      end
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
      if (!push_ok) overflow <= 1'b1;
      if (!pop_ok) underflow <= 1'b1;
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [IW-1:0] ridx;
    assign ridx = wrap_add(head, k);
    assign o_valid[k] = (int'(count) > k);
    assign o_data[k*WIDTH +: WIDTH] = o_valid[k] ? mem[ridx] : '0;
  end

  assign o_count     = count;
  assign o_free      = CW'(DEPTH - int'(count));
  assign o_empty     = (count == '0);
  assign o_full      = (int'(count) == DEPTH);
  assign o_overflow  = overflow;
  assign o_underflow = underflow;

endmodule

// File: tb/tb_ringbuf_mp.sv
// Bench for ringbuf_mp at DEPTH=6, NW=NR=2, WIDTH=8: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_ringbuf_mp;
  localparam int WIDTH = 8;
  localparam int DEPTH = 6;
  localparam int NW = 2;
  localparam int NR = 2;
  localparam int CW = $clog2(DEPTH + 1);

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b0;
  logic           i_flush = 1'b0;
  logic [1:0]     i_wnum = '0;
  logic [15:0]    i_data = '0;
  logic [1:0]     i_rnum = '0;
  logic [15:0]    o_data;
  logic [1:0]     o_valid;
  logic [CW-1:0]  o_count;
  logic [CW-1:0]  o_free;
  logic           o_empty;
  logic           o_full;
  logic           o_overflow;
  logic           o_underflow;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model
  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_unf;

  ringbuf_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NW(NW), .NR(NR)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_wnum(i_wnum),
    .i_data(i_data), .i_rnum(i_rnum), .o_data(o_data), .o_valid(o_valid),
    .o_count(o_count), .o_free(o_free), .o_empty(o_empty), .o_full(o_full),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  // Expected {count, free, empty, full, valid, data, ovf, unf} from the model queue.
  function automatic logic [27:0] model_vec();
    logic [2:0]  c;
    logic [2:0]  f;
    logic [1:0]  v;
    logic [15:0] d;
    c = 3'(q.size());
    f = 3'(DEPTH - q.size());
    v = '0;
    d = '0;
    for (int k = 0; k < NR; k++) begin
      if (q.size() > k) begin
        v[k] = 1'b1;
        d[k*8 +: 8] = q[k];
      end
    end
    return {c, f, (q.size() == 0), (q.size() == DEPTH), v, d, m_ovf, m_unf};
  endfunction

  // Applies one cycle of stimulus, advances the model, samples 1 time unit after the edge.
  task automatic drive(input int wnum, input logic [7:0] d0, input logic [7:0] d1,
                       input int rnum, input logic flush, input logic rst);
    logic push_ok;
    logic pop_ok;
    i_wnum  = 2'(wnum);
    i_data  = {d1, d0};
    i_rnum  = 2'(rnum);
    i_flush = flush;
    i_rst   = rst;
    if (rst || flush) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      push_ok = (wnum <= NW) && (wnum <= DEPTH - q.size());
      pop_ok  = (rnum <= NR) && (rnum <= q.size());
      if (pop_ok) for (int k = 0; k < rnum; k++) void'(q.pop_front());
      if (push_ok) begin
        if (wnum > 0) q.push_back(d0);
        if (wnum > 1) q.push_back(d1);
      end
      if (!push_ok) m_ovf = 1'b1;
      if (!pop_ok) m_unf = 1'b1;
    end
    @(posedge i_clk);
    #1;
    i_wnum = '0; i_rnum = '0; i_flush = 1'b0; i_rst = 1'b0; i_data = '0;
  endtask

  task automatic test_reset();
    drive(0, 8'h00, 8'h00, 0, 1'b0, 1'b1);
    tests_run++;
    if ({o_empty, o_full, o_count, o_free, o_valid, o_data, o_overflow, o_underflow} !==
        {1'b1, 1'b0, 3'd0, 3'd6, 2'b00, 16'h0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state got e=%0b f=%0b c=%0d fr=%0d v=%b d=%h ov=%0b un=%0b want e=1 f=0 c=0 fr=6 v=00 d=0000 ov=0 un=0",
               o_empty, o_full, o_count, o_free, o_valid, o_data, o_overflow, o_underflow);
    end
  endtask

  task automatic test_fill_overflow();
    drive(0, 0, 0, 0, 1'b0, 1'b1);
    drive(2, 8'h11, 8'h22, 0, 1'b0, 1'b0);
    drive(2, 8'h33, 8'h44, 0, 1'b0, 1'b0);
    drive(2, 8'h55, 8'h66, 0, 1'b0, 1'b0);
    tests_run++;
    if ({o_full, o_count, o_free} !== {1'b1, 3'd6, 3'd0}) begin
      tests_failed++;
      $display("FAIL fill_full got full=%0b count=%0d free=%0d want full=1 count=6 free=0", o_full, o_count, o_free);
    end
    drive(1, 8'h77, 8'h00, 0, 1'b0, 1'b0);
    tests_run++;
    if ({o_overflow, o_count, o_data} !== {1'b1, 3'd6, 16'h2211}) begin
      tests_failed++;
      $display("FAIL fill_overflow got ovf=%0b count=%0d data=%h want ovf=1 count=6 data=2211", o_overflow, o_count, o_data);
    end
    drive(0, 0, 0, 2, 1'b0, 1'b0);
    tests_run++;
    if (o_data !== 16'h4433) begin
      tests_failed++;
      $display("FAIL fill_pop1 got data=%h want 4433", o_data);
    end
    drive(0, 0, 0, 2, 1'b0, 1'b0);
    tests_run++;
    if ({o_data, o_count, o_overflow} !== {16'h6655, 3'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL fill_pop2 got data=%h count=%0d ovf=%0b want data=6655 count=2 ovf=1", o_data, o_count, o_overflow);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_bytes[4];
    exp_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    drive(0, 0, 0, 0, 1'b0, 1'b1);
    drive(2, 8'h01, 8'h02, 0, 1'b0, 1'b0);
    drive(2, 8'h03, 8'h04, 0, 1'b0, 1'b0);
    drive(0, 0, 0, 2, 1'b0, 1'b0);
    drive(0, 0, 0, 2, 1'b0, 1'b0);
    drive(2, 8'hA1, 8'hA2, 0, 1'b0, 1'b0);
    drive(2, 8'hA3, 8'hA4, 0, 1'b0, 1'b0);
    tests_run++;
    if ({o_count, o_data} !== {3'd4, 16'hA2A1}) begin
      tests_failed++;
      $display("FAIL wrap_fill got count=%0d data=%h want count=4 data=a2a1", o_count, o_data);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({o_valid[0], o_data[7:0]} !== {1'b1, exp_bytes[i]}) begin
        tests_failed++;
        $display("FAIL wrap_order[%0d] got v=%0b d=%h want v=1 d=%h", i, o_valid[0], o_data[7:0], exp_bytes[i]);
      end
      drive(0, 0, 0, 1, 1'b0, 1'b0);
    end
    tests_run++;
    if ({o_count, o_empty, o_underflow} !== {3'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL wrap_drain got count=%0d empty=%0b unf=%0b want 0 1 0", o_count, o_empty, o_underflow);
    end
  endtask

  task automatic test_full_simul();
    drive(0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(2, 8'(8'h10 + 2*i), 8'(8'h11 + 2*i), 0, 1'b0, 1'b0);
    drive(1, 8'hEE, 0, 1, 1'b0, 1'b0);
    tests_run++;
    if ({o_count, o_overflow, o_underflow, o_data} !== {3'd5, 1'b1, 1'b0, 16'h1211}) begin
      tests_failed++;
      $display("FAIL full_simul got count=%0d ovf=%0b unf=%0b data=%h want 5 1 0 1211",
               o_count, o_overflow, o_underflow, o_data);
    end
  endtask

  task automatic test_empty_underflow();
    drive(0, 0, 0, 0, 1'b0, 1'b1);
    drive(0, 0, 0, 1, 1'b0, 1'b0);
    tests_run++;
    if ({o_underflow, o_overflow, o_count} !== {1'b1, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL empty_underflow got unf=%0b ovf=%0b count=%0d want 1 0 0", o_underflow, o_overflow, o_count);
    end
    drive(1, 8'h5A, 0, 1, 1'b0, 1'b0);
    tests_run++;
    if ({o_count, o_data, o_valid} !== {3'd1, 16'h005A, 2'b01}) begin
      tests_failed++;
      $display("FAIL empty_push_pop got count=%0d data=%h valid=%b want 1 005a 01", o_count, o_data, o_valid);
    end
  endtask

  task automatic test_flush();
    drive(0, 0, 0, 0, 1'b0, 1'b1);
    drive(2, 8'hC1, 8'hC2, 0, 1'b0, 1'b0);
    drive(1, 8'hC3, 0, 0, 1'b0, 1'b0);
    drive(0, 0, 0, 3, 1'b0, 1'b0);
    drive(3, 0, 0, 0, 1'b0, 1'b0);
    tests_run++;
    if ({o_count, o_overflow, o_underflow} !== {3'd3, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL flush_setup got count=%0d ovf=%0b unf=%0b want 3 1 1", o_count, o_overflow, o_underflow);
    end
    drive(2, 8'hD1, 8'hD2, 0, 1'b1, 1'b0);
    tests_run++;
    if ({o_count, o_empty, o_overflow, o_underflow, o_valid, o_data} !== {3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0}) begin
      tests_failed++;
      $display("FAIL flush_clear got count=%0d empty=%0b ovf=%0b unf=%0b v=%b d=%h want 0 1 0 0 00 0000",
               o_count, o_empty, o_overflow, o_underflow, o_valid, o_data);
    end
  endtask

  task automatic test_random();
    int w;
    int r;
    logic fl;
    logic [27:0] exp;
    drive(0, 0, 0, 0, 1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      w  = $urandom_range(0, 3);
      r  = $urandom_range(0, 3);
      fl = ($urandom_range(0, 40) == 0);
      drive(w, 8'($urandom), 8'($urandom), r, fl, 1'b0);
      exp = model_vec();
      tests_run++;
      if ({o_count, o_free, o_empty, o_full, o_valid, o_data, o_overflow, o_underflow} !== exp) begin
        tests_failed++;
        $display("FAIL random[%0d] got %h want %h", n,
                 {o_count, o_free, o_empty, o_full, o_valid, o_data, o_overflow, o_underflow}, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(2, 8'h91, 8'h92, 0, 1'b0, 1'b0);
    drive(0, 0, 0, 3, 1'b0, 1'b0);
    drive(2, 8'h93, 8'h94, 1, 1'b0, 1'b1);
    tests_run++;
    if ({o_empty, o_full, o_count, o_free, o_valid, o_data, o_overflow, o_underflow} !==
        {1'b1, 1'b0, 3'd0, 3'd6, 2'b00, 16'h0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_midstream got e=%0b c=%0d fr=%0d v=%b d=%h ov=%0b un=%0b want 1 0 6 00 0000 0 0",
               o_empty, o_count, o_free, o_valid, o_data, o_overflow, o_underflow);
    end
  endtask

  initial begin
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #2;
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_full_simul();
    test_empty_underflow();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ringbuf_mp.md
Name: ringbuf_mp

Overview:
Multi-port, parametrised ring buffer and next generation of the single-port ring buffer. It is intended for reorder-buffer, instruction-queue and free-list storage in the out-of-order core.
- Accepts up to NW entries and retires up to NR entries per cycle.
- Any DEPTH is supported, not only powers of two.
- Provides occupancy counts, sticky overflow/underflow error flags and a single-cycle flush.

Parameters:
WIDTH, 8, data bits per entry
DEPTH, 16, number of entries; any integer >= 2, power of two not required
NW, 2, write lanes per cycle (1..4)
NR, 2, read lanes per cycle (1..4)
CW, $clog2(DEPTH+1), width of count outputs (derived, not overridden)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_flush  input  1  synchronous empty of buffer, clears error flags
i_wnum  input  $clog2(NW+1)  number of entries to push this cycle, lanes 0..i_wnum-1
i_data  input  NW*WIDTH  write data, lane k at bits [k*WIDTH +: WIDTH]
i_rnum  input  $clog2(NR+1)  number of entries to pop this cycle
o_data  output  NR*WIDTH  entries head+0..head+NR-1, lane k at [k*WIDTH +: WIDTH]
o_valid  output  NR  lane k set when count > k
o_count  output  CW  occupied entries
o_free  output  CW  DEPTH - o_count
o_empty  output  1  count == 0
o_full  output  1  count == DEPTH
o_overflow  output  1  sticky: push rejected
o_underflow  output  1  sticky: pop rejected

Behaviour:
- State: head index, tail index, each 0..DEPTH-1; count register 0..DEPTH; storage array DEPTH x WIDTH.
- Index advance is modulo DEPTH via compare-and-subtract: idx + n >= DEPTH gives idx + n - DEPTH. No power-of-two masking.
- Reset (i_rst high at edge):
  - head = tail = count = 0; overflow = underflow = 0; storage cleared to 0.
  - Outputs after reset: o_empty=1, o_full=0, o_count=0, o_free=DEPTH, o_valid=0, o_data=0.
- Priority per edge: i_rst > i_flush > normal operation.
- i_flush: head = tail = count = 0 and both sticky flags cleared; pushes and pops in that cycle are ignored. Storage content need not be cleared.
- Push acceptance is all-or-nothing and uses pre-edge state only:
  - Accept when i_wnum <= NW and i_wnum <= o_free.
  - A pop in the same cycle does NOT create room for that cycle's push.
- Rejected push: no entry written, tail unchanged, o_overflow set next cycle and held until reset/flush.
- Pop acceptance is all-or-nothing:
  - Accept when i_rnum <= NR and i_rnum <= o_count.
  - An entry pushed in the same cycle cannot be popped that cycle.
- Rejected pop: head unchanged, o_underflow set and held.
- Push accepted: lane k (k < i_wnum) is written to storage[(tail+k) mod DEPTH]; tail advances by i_wnum.
- Pop accepted: head advances by i_rnum. Popped slots are cleared to 0 on the same edge, unless that slot is written by an accepted push in the same cycle, in which case the write wins.
- count_next = count + accepted_wnum - accepted_rnum. Simultaneous accepted push and pop are legal at full and at empty.
- Read path: o_data lane k is combinational from storage[(head+k) mod DEPTH] when o_valid[k], otherwise 0. No fall-through: data pushed at edge t first appears on o_data after edge t.
- o_count, o_free, o_empty, o_full, o_valid are decoded from registered count only. Combinational outputs must not depend on i_wnum or i_rnum.
- A push or pop count of 0 is a no-op and never sets an error flag.
- Index wrap must be exact at any DEPTH: head/tail == DEPTH-1 advanced by 1 gives 0, advanced by 2 gives 1.

Test Plan:
- Reset with DEPTH=6, NW=NR=2, WIDTH=8 → o_empty=1, o_free=6, o_valid=00, o_data=0, o_overflow=o_underflow=0.
- Push pairs {11,22}, {33,44}, {55,66} → o_full=1, o_count=6. Then push 1 more → rejected, o_overflow=1, contents unchanged. Then pop 2 → o_data lanes = 11,22 then 33,44.
- Wrap: push 4, pop 4, then push {A1,A2} and {A3,A4} → entries occupy indices 4,5,0,1. Pops return A1,A2,A3,A4 in order; o_count returns to 0.
- Full with i_wnum=1, i_rnum=1 simultaneously → push rejected (o_free=0 pre-edge), pop accepted, o_count=5, o_overflow=1.
- Empty with i_rnum=1 → o_underflow=1, head unchanged. Push 1 and pop 1 in the same cycle from empty → pop rejected, push accepted, o_count=1.
- Buffer holding 3 entries with both flags set, assert i_flush together with i_wnum=2 → o_count=0, o_empty=1, flags cleared, no data written. Assert i_rst mid-stream → reset values next cycle.
